// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl: coarse-to-fine DCO tuning controller.
// After a power-up wait, runs a 5-bit SAR on the large capacitor bank, then a
// 5-bit SAR on the medium bank, then tracks continuously with the small bank.
// Each decision uses a window of SETTLE ignored cycles followed by
// 2^AVG_LOG2 summed freq_err samples.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   en           - acquisition request (level); low returns to IDLE
//   freq_err     - signed measured-minus-target frequency (positive: too fast)
//   dco_pd       - DCO power-down (registered, high in IDLE)
//   tdc_pd       - TDC power-down (registered, high in IDLE)
//   c_l_code     - large-bank code
//   c_m_code     - medium-bank code
//   c_s_code     - small-bank code
//   state        - FSM state (IDLE=0 PWRUP=1 LARGE=2 MEDIUM=3 TRACK=4)
//   busy         - high in PWRUP, LARGE and MEDIUM
//   channel_lock - sticky tracking lock indicator
module dco_tune_ctrl #(
  parameter int unsigned PWRUP    = 16,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned LOCK_TOL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [11:0] freq_err,
  output logic               dco_pd,
  output logic               tdc_pd,
  output logic [4:0]         c_l_code,
  output logic [4:0]         c_m_code,
  output logic [7:0]         c_s_code,
  output logic [2:0]         state,
  output logic               busy,
  output logic               channel_lock
);

  localparam int unsigned AW     = 12 + AVG_LOG2 + 1;
  localparam int unsigned CW     = 16;
  localparam int unsigned WinLen = SETTLE + (1 << AVG_LOG2);

  localparam logic [CW-1:0]        PwrupLast = CW'(PWRUP - 1);
  localparam logic [CW-1:0]        WinLast   = CW'(WinLen - 1);
  localparam logic [CW-1:0]        SettleCnt = CW'(SETTLE);
  localparam logic signed [AW-1:0] TolS      = AW'(LOCK_TOL);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPwrup  = 3'd1,
    StLarge  = 3'd2,
    StMedium = 3'd3,
    StTrack  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [2:0]            bit_q, bit_d;
  logic [4:0]            cl_q, cl_d;
  logic [4:0]            cm_q, cm_d;
  logic [7:0]            cs_q, cs_d;
  logic [2:0]            lcnt_q, lcnt_d;
  logic                  lock_q, lock_d;
  logic                  pd_q;

  logic signed [AW-1:0]  err_ext;
  logic signed [AW-1:0]  sum;
  logic                  sample, win_end, sum_pos, sum_neg, in_tol, abort;
  logic [4:0]            code;

  assign err_ext = {{(AW-12){freq_err[11]}}, freq_err};
  // Window sum including the sample presented this cycle; used at window end.
  assign sum     = acc_q + err_ext;
  assign sample  = (cnt_q >= SettleCnt);
  assign win_end = (cnt_q == WinLast);
  assign sum_neg = sum[AW-1];
  assign sum_pos = !sum[AW-1] && (sum != '0);
  assign in_tol  = (sum <= TolS) && (sum >= -TolS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    cl_d    = cl_q;
    cm_d    = cm_q;
    cs_d    = cs_q;
    lcnt_d  = lcnt_q;
    lock_d  = lock_q;
    code    = 5'd0;
    abort   = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StPwrup;
          cnt_d   = '0;
        end
      end
      StPwrup: begin
        if (cnt_q == PwrupLast) begin
          state_d = StLarge;
          cnt_d   = '0;
          acc_d   = '0;
          bit_d   = 3'd4;
          cl_d    = 5'b10000;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StLarge, StMedium: begin
        if (sample) acc_d = sum;
        if (win_end) begin
          cnt_d = '0;
          acc_d = '0;
          code  = (state_q == StLarge) ? cl_q : cm_q;
          // Trial bit survives only when the DCO was measured too fast.
          if (!sum_pos) code[bit_q] = 1'b0;
          if (bit_q != 3'd0) begin
            code[bit_q - 3'd1] = 1'b1;
            bit_d              = bit_q - 3'd1;
          end else if (state_q == StLarge) begin
            state_d = StMedium;
            bit_d   = 3'd4;
          end else begin
            state_d = StTrack;
          end
          if (state_q == StLarge) begin
            cl_d = code;
            if (bit_q == 3'd0) cm_d = 5'b10000;
          end else begin
            cm_d = code;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StTrack: begin
        if (sample) acc_d = sum;
        if (win_end) begin
          cnt_d = '0;
          acc_d = '0;
          if (sum_pos && (cs_q != 8'hff)) begin
            cs_d = cs_q + 8'd1;
          end else if (sum_neg && (cs_q != 8'h00)) begin
            cs_d = cs_q - 8'd1;
          end
          if (in_tol) begin
            if (lcnt_q != 3'd4) lcnt_d = lcnt_q + 3'd1;
          end else begin
            lcnt_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (lcnt_d == 3'd4) lock_d = 1'b1;
      end
      default: abort = 1'b1;
    endcase

    if (abort || ((state_q != StIdle) && !en)) begin
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
      bit_d   = 3'd0;
      cl_d    = 5'd0;
      cm_d    = 5'd0;
      cs_d    = 8'd128;
      lcnt_d  = 3'd0;
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      bit_q   <= 3'd0;
      cl_q    <= 5'd0;
      cm_q    <= 5'd0;
      cs_q    <= 8'd128;
      lcnt_q  <= 3'd0;
      lock_q  <= 1'b0;
      pd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      cl_q    <= cl_d;
      cm_q    <= cm_d;
      cs_q    <= cs_d;
      lcnt_q  <= lcnt_d;
      lock_q  <= lock_d;
      // Power-down follows the state one cycle late.
      pd_q    <= (state_q == StIdle);
    end
  end

  assign state        = state_q;
  assign busy         = (state_q == StPwrup) || (state_q == StLarge) || (state_q == StMedium);
  assign dco_pd       = pd_q;
  assign tdc_pd       = pd_q;
  assign c_l_code     = cl_q;
  assign c_m_code     = cm_q;
  assign c_s_code     = cs_q;
  assign channel_lock = lock_q;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Bench for dco_tune_ctrl: directed stimulus with literal checkpoints plus a
// timeline model (cycles since activation -> phase, window, bit) compared
// against the DUT on every falling edge.
module tb_dco_tune_ctrl;

  localparam int PWRUP    = 16;
  localparam int SETTLE   = 4;
  localparam int AVG_LOG2 = 3;
  localparam int LOCK_TOL = 2;
  localparam int WL       = SETTLE + (1 << AVG_LOG2);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic               closed = 1'b0;
  logic signed [11:0] fe_drv = 12'sd0;
  logic signed [11:0] freq_err;
  logic               dco_pd, tdc_pd, busy, channel_lock;
  logic [4:0]         c_l_code, c_m_code;
  logic [7:0]         c_s_code;
  logic [2:0]         state;

  dco_tune_ctrl #(
    .PWRUP   (PWRUP),
    .SETTLE  (SETTLE),
    .AVG_LOG2(AVG_LOG2),
    .LOCK_TOL(LOCK_TOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .freq_err    (freq_err),
    .dco_pd      (dco_pd),
    .tdc_pd      (tdc_pd),
    .c_l_code    (c_l_code),
    .c_m_code    (c_m_code),
    .c_s_code    (c_s_code),
    .state       (state),
    .busy        (busy),
    .channel_lock(channel_lock)
  );

  // Closed-loop plant: DCO frequency error falls as the large code rises.
  assign freq_err = closed ? (12'sd20 - $signed({7'd0, c_l_code})) : fe_drv;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic m_active, m_lock, m_pd;
  int   m_t, m_wsum, m_lres, m_mres, m_cs, m_run;

  function automatic void m_clear();
    m_active = 1'b0;
    m_t      = 0;
    m_wsum   = 0;
    m_lres   = 0;
    m_mres   = 0;
    m_cs     = 128;
    m_run    = 0;
    m_lock   = 1'b0;
  endfunction

  function automatic int m_state();
    int win;
    if (!m_active) return 0;
    if (m_t < PWRUP) return 1;
    win = (m_t - PWRUP) / WL;
    if (win < 5) return 2;
    if (win < 10) return 3;
    return 4;
  endfunction

  function automatic logic [24:0] m_vec();
    int st, cl, cm, win;
    logic b;
    st = m_state();
    cl = 0;
    cm = 0;
    if (st >= 2) begin
      win = (m_t - PWRUP) / WL;
      if (win < 5) begin
        cl = m_lres + (1 << (4 - win));
      end else begin
        cl = m_lres;
        if (win < 10) cm = m_mres + (1 << (9 - win));
        else cm = m_mres;
      end
    end
    b = (st >= 1) && (st <= 3);
    return {3'(st), m_pd, m_pd, b, m_lock, 5'(cl), 5'(cm), 8'(m_cs)};
  endfunction

  function automatic void m_decide(input int win, input int s);
    if (win < 5) begin
      if (s > 0) m_lres += (1 << (4 - win));
    end else if (win < 10) begin
      if (s > 0) m_mres += (1 << (9 - win));
    end else begin
      if (s > 0 && m_cs < 255) m_cs++;
      else if (s < 0 && m_cs > 0) m_cs--;
      if (s <= LOCK_TOL && s >= -LOCK_TOL) m_run++;
      else m_run = 0;
      if (m_run >= 4) m_lock = 1'b1;
    end
  endfunction

  // Advance the model across the next rising edge using the present inputs.
  function automatic void m_step();
    int st0, u, pos, fe;
    st0 = m_state();
    fe  = freq_err;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (!en) begin
      m_clear();
    end else begin
      if (m_t >= PWRUP) begin
        u   = m_t - PWRUP;
        pos = u % WL;
        if (pos >= SETTLE) m_wsum += fe;
        if (pos == WL - 1) begin
          m_decide(u / WL, m_wsum);
          m_wsum = 0;
        end
      end
      m_t++;
    end
    m_pd = (st0 == 0);
  endfunction

  // Compare process: outputs are stable mid-cycle; inputs change only after rising edges.
  always @(negedge clk) begin
    logic [24:0] dv, ev;
    if (!rst_n) begin
      m_clear();
      m_pd = 1'b1;
    end
    if (chk_en) begin
      ev = m_vec();
      dv = {state, dco_pd, tdc_pd, busy, channel_lock, c_l_code, c_m_code, c_s_code};
      total++;
      if (dv !== ev) begin
        bad++;
        $display("FAIL model_cmp t=%0t got st=%0d pd=%b%b busy=%b lock=%b l=%0d m=%0d s=%0d expected %h (dut %h)",
                 $time, state, dco_pd, tdc_pd, busy, channel_lock, c_l_code, c_m_code, c_s_code,
                 ev, dv);
      end
    end
    if (rst_n) m_step();
  end

  // ---------------- directed stimulus ----------------
  initial begin
    m_clear();
    m_pd = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(3);
    rst_n = 1'b1;

    // Idle with en=0 for 100 cycles.
    tick(100);
    check("idle_state", state, 0);
    check("idle_dco_pd", dco_pd, 1);
    check("idle_tdc_pd", tdc_pd, 1);
    check("idle_cs", c_s_code, 128);
    check("idle_cl", c_l_code, 0);
    check("idle_busy", busy, 0);
    check("idle_lock", channel_lock, 0);

    // Closed-loop LARGE search.
    en = 1'b1;
    closed = 1'b1;
    tick(1);
    check("pwrup_state", state, 1);
    check("pwrup_pd_delay", dco_pd, 1);
    tick(1);
    check("pwrup_dco_pd_fall", dco_pd, 0);
    check("pwrup_tdc_pd_fall", tdc_pd, 0);
    tick(15);
    check("large_entry_state", state, 2);
    check("large_entry_cl", c_l_code, 16);
    check("large_busy", busy, 1);
    tick(60);
    check("large_result_cl", c_l_code, 19);
    check("medium_entry_state", state, 3);
    check("medium_entry_cm", c_m_code, 16);

    // Abort mid-MEDIUM, then restart.
    closed = 1'b0;
    fe_drv = 12'sd0;
    tick(30);
    en = 1'b0;
    tick(1);
    check("abort_state", state, 0);
    check("abort_cl", c_l_code, 0);
    check("abort_cm", c_m_code, 0);
    check("abort_pd_delay", dco_pd, 0);
    tick(1);
    check("abort_pd_high", dco_pd, 1);

    // Constant +5: all-ones codes and small-bank saturation at 255.
    en = 1'b1;
    fe_drv = 12'sd5;
    tick(1);
    check("restart_state", state, 1);
    tick(16 + 60);
    check("pos_cl", c_l_code, 31);
    check("pos_medium", state, 3);
    tick(60);
    check("pos_cm", c_m_code, 31);
    check("pos_track", state, 4);
    check("pos_track_cs", c_s_code, 128);
    tick(WL * 140);
    check("pos_cs_sat", c_s_code, 255);
    check("pos_no_lock", channel_lock, 0);

    // Reset mid-TRACK abandons the search.
    rst_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_cs", c_s_code, 128);
    check("rst_cl", c_l_code, 0);
    en = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_hold_idle", state, 0);

    // Constant -5: all-zero codes, then lock with zero error.
    en = 1'b1;
    fe_drv = -12'sd5;
    tick(1);
    check("neg_pwrup", state, 1);
    tick(16 + 60);
    check("neg_cl", c_l_code, 0);
    tick(60);
    check("neg_cm", c_m_code, 0);
    check("neg_track", state, 4);
    fe_drv = 12'sd0;
    tick(47);
    check("lock_not_yet", channel_lock, 0);
    tick(1);
    check("lock_rise", channel_lock, 1);
    check("lock_cs_hold", c_s_code, 128);
    fe_drv = 12'sd5;
    tick(WL);
    check("lock_sticky", channel_lock, 1);
    check("lock_cs_step", c_s_code, 129);
    fe_drv = -12'sd5;
    tick(WL * 135);
    check("neg_cs_sat", c_s_code, 0);
    en = 1'b0;
    tick(2);
    check("final_idle", state, 0);
    check("final_lock_clear", channel_lock, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
